// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: RV32I opcode constants, the control bundle
// carried from ID to EX, and the bubble value that makes EX a no-op.
package id_ex_stage_reg_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       is_jump;
        logic       is_load;
        logic [3:0] d_mem_be;
        logic       d_mem_wen;
        logic       d_mem_read;
        logic       rf_we;
        logic [1:0] rw_src;
        logic [1:0] op_src;
    } ctrl_t;

    // D_MEM_WEN is active-low, so a bubble leaves it high.
    localparam ctrl_t CTRL_BUBBLE = '{
        alu_op:     4'd0,
        alu_src_a:  1'b0,
        alu_src_b:  1'b0,
        is_jump:    1'b0,
        is_load:    1'b0,
        d_mem_be:   4'd0,
        d_mem_wen:  1'b1,
        d_mem_read: 1'b0,
        rf_we:      1'b0,
        rw_src:     2'd0,
        op_src:     2'd0
    };

    function automatic logic uses_rs1(input logic [6:0] opc);
        return (opc == OPC_JALR)  || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
    endfunction

    function automatic logic is_known_opcode(input logic [6:0] opc);
        return uses_rs1(opc) || (opc == OPC_JAL) || (opc == OPC_LUI) || (opc == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// Purely combinational; a flush masks the stall because ID is wrong-path anyway.
module id_ex_stage_reg_hazard_detect
    import id_ex_stage_reg_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       valid_id,
    input  logic       valid_ex,
    input  logic       is_load_ex,
    input  logic [4:0] rd_ex,
    input  logic       flush,
    output logic       load_use,
    output logic       stall
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = uses_rs1(opcode) && (rs1 == rd_ex);
        rs2_hit  = uses_rs2(opcode) && (rs2 == rd_ex);
        load_use = valid_ex && is_load_ex && (rd_ex != 5'd0) && valid_id && (rs1_hit || rs2_hit);
        stall    = load_use && !flush;
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, redirect squash,
// unknown-opcode side-effect suppression and saturating hazard counters.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [31:0]      INSTR_IFID,
    input  logic [31:0]      PC_IFID,
    input  logic             valid_IFID,
    input  logic [3:0]       ALUOp_IFID,
    input  logic             ALUSrcA_IFID,
    input  logic             ALUSrcB_IFID,
    input  logic             isJump_IFID,
    input  logic             isLoad_IFID,
    input  logic [3:0]       D_MEM_BE_IFID,
    input  logic             D_MEM_WEN_IFID,
    input  logic             D_MemRead_IFID,
    input  logic             RF_WE_IFID,
    input  logic [1:0]       RWSrc_IFID,
    input  logic [1:0]       OPSrc_IFID,
    input  logic             flush,
    output logic [3:0]       ALUOp_IDEX,
    output logic             ALUSrcA_IDEX,
    output logic             ALUSrcB_IDEX,
    output logic             isJump_IDEX,
    output logic             isLoad_IDEX,
    output logic [3:0]       D_MEM_BE_IDEX,
    output logic             D_MEM_WEN_IDEX,
    output logic             D_MemRead_IDEX,
    output logic             RF_WE_IDEX,
    output logic [1:0]       RWSrc_IDEX,
    output logic [1:0]       OPSrc_IDEX,
    output logic [31:0]      PC_IDEX,
    output logic [4:0]       rs1_IDEX,
    output logic [4:0]       rs2_IDEX,
    output logic [4:0]       rd_IDEX,
    output logic             valid_IDEX,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [6:0]       opcode;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             load_use;
    logic             unused_instr_bits;
    ctrl_t            ctrl_in;
    ctrl_t            ctrl_q;
    logic [31:0]      pc_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rd_q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] flush_q;

    assign opcode            = INSTR_IFID[6:0];
    assign rd                = INSTR_IFID[11:7];
    assign rs1               = INSTR_IFID[19:15];
    assign rs2               = INSTR_IFID[24:20];
    assign unused_instr_bits = ^{INSTR_IFID[31:25], INSTR_IFID[14:12]};

    id_ex_stage_reg_hazard_detect u_hazard (
        .opcode     (opcode),
        .rs1        (rs1),
        .rs2        (rs2),
        .valid_id   (valid_IFID),
        .valid_ex   (valid_q),
        .is_load_ex (ctrl_q.is_load),
        .rd_ex      (rd_q),
        .flush      (flush),
        .load_use   (load_use),
        .stall      (stall)
    );

    // Unknown opcodes still flow down the pipe but must not write state.
    always_comb begin
        ctrl_in = '{
            alu_op:     ALUOp_IFID,
            alu_src_a:  ALUSrcA_IFID,
            alu_src_b:  ALUSrcB_IFID,
            is_jump:    isJump_IFID,
            is_load:    isLoad_IFID,
            d_mem_be:   D_MEM_BE_IFID,
            d_mem_wen:  D_MEM_WEN_IFID,
            d_mem_read: D_MemRead_IFID,
            rf_we:      RF_WE_IFID,
            rw_src:     RWSrc_IFID,
            op_src:     OPSrc_IFID
        };
        if (!is_known_opcode(opcode)) begin
            ctrl_in.rf_we      = 1'b0;
            ctrl_in.d_mem_read = 1'b0;
            ctrl_in.d_mem_wen  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ctrl_q  <= CTRL_BUBBLE;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush || load_use || !valid_IFID) begin
            ctrl_q  <= CTRL_BUBBLE;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_in;
            pc_q    <= PC_IFID;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
            valid_q <= 1'b1;
        end
    end

    // A flush outranks a coincident load-use, so only one counter moves per edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else if (flush) begin
            if (flush_q != '1) flush_q <= flush_q + CNT_W'(1);
        end else if (load_use) begin
            if (bubble_q != '1) bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign ALUOp_IDEX     = ctrl_q.alu_op;
    assign ALUSrcA_IDEX   = ctrl_q.alu_src_a;
    assign ALUSrcB_IDEX   = ctrl_q.alu_src_b;
    assign isJump_IDEX    = ctrl_q.is_jump;
    assign isLoad_IDEX    = ctrl_q.is_load;
    assign D_MEM_BE_IDEX  = ctrl_q.d_mem_be;
    assign D_MEM_WEN_IDEX = ctrl_q.d_mem_wen;
    assign D_MemRead_IDEX = ctrl_q.d_mem_read;
    assign RF_WE_IDEX     = ctrl_q.rf_we;
    assign RWSrc_IDEX     = ctrl_q.rw_src;
    assign OPSrc_IDEX     = ctrl_q.op_src;
    assign PC_IDEX        = pc_q;
    assign rs1_IDEX       = rs1_q;
    assign rs2_IDEX       = rs2_q;
    assign rd_IDEX        = rd_q;
    assign valid_IDEX     = valid_q;
    assign bubble_cnt     = bubble_q;
    assign flush_cnt      = flush_q;

endmodule
